// File: rtl/forth_pkg.sv
// Shared constants for the Forth CPU front end: dictionary opcodes, token
// kinds, ASCII/delimiter codes and small character helpers.
package forth_pkg;

  localparam logic [2:0] OP_SET         = 3'd0;
  localparam logic [2:0] OP_GET         = 3'd1;
  localparam logic [2:0] OP_ENCODE      = 3'd2;
  localparam logic [2:0] OP_SET_FAST    = 3'd3;
  localparam logic [2:0] OP_GET_FAST    = 3'd4;
  localparam logic [2:0] OP_DELETE      = 3'd5;
  localparam logic [2:0] OP_DELETE_FAST = 3'd6;

  typedef enum logic [1:0] {
    TOK_WORD   = 2'd0,
    TOK_NUMBER = 2'd1,
    TOK_UNDEF  = 2'd2
  } tok_kind_t;

  localparam logic [7:0] ASCII_NUL     = 8'h00;
  localparam logic [7:0] ASCII_TAB     = 8'h09;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_MINUS   = 8'h2D;
  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_9       = 8'h39;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam logic [7:0] ASCII_CASE    = 8'h20;

  // NUL splits words because an all-zero key marks an empty dictionary slot.
  function automatic logic is_delim(input logic [7:0] c);
    return (c == ASCII_SPACE) || (c == ASCII_TAB) || (c == ASCII_LF) ||
           (c == ASCII_CR) || (c == ASCII_NUL);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if ((c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z)) return c & ~ASCII_CASE;
    return c;
  endfunction

endpackage

// File: rtl/word_tokenizer_num_accum.sv
// Decimal literal tracker for one word: optional leading '-', then digits,
// accumulated modulo 2^VALUE_WIDTH.
module num_accum
  import forth_pkg::*;
#(
  parameter int VALUE_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_step,
  input  logic                   i_first,
  input  logic [7:0]             i_char,
  output logic [VALUE_WIDTH-1:0] o_literal,
  output logic                   o_is_num
);

  logic [VALUE_WIDTH-1:0] acc;
  logic                   negate;
  logic                   num_ok;
  logic                   has_digit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc       <= '0;
      negate    <= 1'b0;
      num_ok    <= 1'b1;
      has_digit <= 1'b0;
    end else if (i_clear) begin
      acc       <= '0;
      negate    <= 1'b0;
      num_ok    <= 1'b1;
      has_digit <= 1'b0;
    end else if (i_step) begin
      if (is_digit(i_char)) begin
        acc       <= acc * VALUE_WIDTH'(10) + VALUE_WIDTH'(i_char[3:0]);
        has_digit <= 1'b1;
      end else if ((i_char == ASCII_MINUS) && i_first) begin
        negate <= 1'b1;
      end else begin
        num_ok <= 1'b0;
      end
    end
  end

  // A lone "-" never saw a digit, so it is not a number.
  assign o_is_num  = num_ok & has_digit;
  assign o_literal = negate ? (~acc + VALUE_WIDTH'(1)) : acc;

endmodule

// File: rtl/word_tokenizer.sv
// Splits a byte stream into words, looks each up in the dictionary and emits
// one WORD/NUMBER/UNDEFINED token per word. WORD_TOKENIZER_CASE_FOLD_EN folds
// a-z to A-Z in the key.
module word_tokenizer
  import forth_pkg::*;
#(
  parameter int KEY_LENGTH   = 8,
  parameter int VALUE_WIDTH  = 32,
  parameter int ENTRIES      = 10,
  parameter int ENTRIES_BITS = $clog2(ENTRIES)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_char_valid,
  input  logic [7:0]              i_char,
  output logic                    o_char_ready,
  output logic                    o_dict_ready,
  output logic [2:0]              o_dict_op,
  output logic [7:0]              o_dict_key [KEY_LENGTH],
  input  logic                    i_dict_done,
  input  logic                    i_dict_err,
  input  logic [ENTRIES_BITS-1:0] i_dict_index,
  input  logic [VALUE_WIDTH-1:0]  i_dict_value,
  output logic                    o_tok_valid,
  input  logic                    i_tok_ready,
  output logic [1:0]              o_tok_kind,
  output logic [ENTRIES_BITS-1:0] o_tok_index,
  output logic [VALUE_WIDTH-1:0]  o_tok_value,
  output logic                    o_tok_long,
  output logic [1:0]              o_state
);

  // Handshakes: a byte moves on i_char_valid & o_char_ready & i_en; a token
  // moves on o_tok_valid & i_tok_ready & i_en, and o_tok_valid never drops
  // before that. Nothing changes while i_en is low.

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_LOOKUP  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_EMIT    = 2'd3;

  localparam int LEN_W = $clog2(KEY_LENGTH + 2);
  localparam logic [LEN_W-1:0] LEN_KEY = LEN_W'(KEY_LENGTH);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(KEY_LENGTH + 1);

  logic [1:0]              state;
  logic [LEN_W-1:0]        len;
  logic [7:0]              key [KEY_LENGTH];
  logic                    long_flag;
  tok_kind_t               tok_kind;
  logic [ENTRIES_BITS-1:0] tok_index;
  logic [VALUE_WIDTH-1:0]  tok_value;
  logic                    tok_long;

  logic                    char_fire;
  logic                    char_delim;
  logic                    word_char;
  logic                    tok_accept;
  logic [7:0]              key_char;
  logic [VALUE_WIDTH-1:0]  num_literal;
  logic                    num_is_num;

  assign char_fire  = i_en & i_char_valid & (state == ST_COLLECT);
  assign char_delim = is_delim(i_char);
  assign word_char  = char_fire & ~char_delim;
  assign tok_accept = i_en & (state == ST_EMIT) & i_tok_ready;

`ifdef WORD_TOKENIZER_CASE_FOLD_EN
  assign key_char = to_upper(i_char);
`else
  assign key_char = i_char;
`endif

  num_accum #(
    .VALUE_WIDTH(VALUE_WIDTH)
  ) u_num_accum (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (tok_accept),
    .i_step   (word_char),
    .i_first  (len == '0),
    .i_char   (i_char),
    .o_literal(num_literal),
    .o_is_num (num_is_num)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_COLLECT;
      len       <= '0;
      long_flag <= 1'b0;
      tok_kind  <= TOK_WORD;
      tok_index <= '0;
      tok_value <= '0;
      tok_long  <= 1'b0;
      for (int i = 0; i < KEY_LENGTH; i++) key[i] <= '0;
    end else if (i_en) begin
      case (state)
        ST_COLLECT: begin
          if (word_char) begin
            if (len < LEN_KEY) begin
              for (int i = 0; i < KEY_LENGTH; i++)
                if (len == LEN_W'(i)) key[i] <= key_char;
            end else begin
              long_flag <= 1'b1;
            end
            if (len != LEN_MAX) len <= len + LEN_W'(1);
          end else if (char_fire && (len != '0)) begin
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state <= ST_WAIT;
        ST_WAIT: begin
          if (i_dict_done) begin
            state    <= ST_EMIT;
            tok_long <= long_flag;
            // A dictionary hit wins even when the word also parses as a number.
            if (!i_dict_err) begin
              tok_kind  <= TOK_WORD;
              tok_index <= i_dict_index;
              tok_value <= i_dict_value;
            end else if (num_is_num) begin
              tok_kind  <= TOK_NUMBER;
              tok_index <= '0;
              tok_value <= num_literal;
            end else begin
              tok_kind  <= TOK_UNDEF;
              tok_index <= '0;
              tok_value <= '0;
            end
          end
        end
        ST_EMIT: begin
          if (tok_accept) begin
            state     <= ST_COLLECT;
            len       <= '0;
            long_flag <= 1'b0;
            tok_kind  <= TOK_WORD;
            tok_index <= '0;
            tok_value <= '0;
            tok_long  <= 1'b0;
            for (int i = 0; i < KEY_LENGTH; i++) key[i] <= '0;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

  assign o_char_ready = (state == ST_COLLECT);
  assign o_dict_ready = (state == ST_LOOKUP);
  assign o_dict_op    = OP_GET;
  assign o_dict_key   = key;
  assign o_tok_valid  = (state == ST_EMIT);
  assign o_tok_kind   = tok_kind;
  assign o_tok_index  = tok_index;
  assign o_tok_value  = tok_value;
  assign o_tok_long   = tok_long;
  assign o_state      = state;

endmodule

// File: doc/word_tokenizer.md
Name: word_tokenizer

Overview:
Upstream stage of the dictionary block in the Forth CPU. Consumes a byte stream (console/UART), splits it on whitespace into words, and packs each word into a dictionary key. Issues one GET per word to the dictionary and emits one classified token per word: dictionary hit, decimal number literal, or undefined word. Tokens go to the interpreter/execute stage.

Parameters:
KEY_LENGTH, 8, characters per key; must match the dictionary's KEY_LENGTH
VALUE_WIDTH, 32, dictionary value width and number-literal width (dictionary instantiated with VALUE_LENGTH=1)
ENTRIES, 10, dictionary entry count; index width ENTRIES_BITS=$clog2(ENTRIES)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_en  in  1  when 0, all state and outputs hold
i_char_valid  in  1  input byte valid
i_char  in  8  input byte (ASCII)
o_char_ready  out  1  byte accepted when i_char_valid & o_char_ready & i_en
o_dict_ready  out  1  one-cycle dictionary request strobe
o_dict_op  out  3  dictionary opcode; always OP_GET (1)
o_dict_key  out  8 x KEY_LENGTH (unpacked)  packed key; element n = character n
i_dict_done  in  1  dictionary completion
i_dict_err  in  1  dictionary miss; valid with i_dict_done
i_dict_index  in  ENTRIES_BITS  hit index; valid with i_dict_done
i_dict_value  in  VALUE_WIDTH  hit value; valid with i_dict_done
o_tok_valid  out  1  token valid; held until accepted
i_tok_ready  in  1  consumer accept
o_tok_kind  out  2  0=WORD (hit), 1=NUMBER, 2=UNDEFINED
o_tok_index  out  ENTRIES_BITS  dictionary index (WORD), else 0
o_tok_value  out  VALUE_WIDTH  dictionary value (WORD), literal (NUMBER), else 0
o_tok_long  out  1  word exceeded KEY_LENGTH characters and was truncated

Behaviour:
- Reset (async): state COLLECT; length=0; key cleared to all 0; accumulator=0; o_char_ready=1 (subject to state); o_dict_ready=0; o_dict_op=1; o_tok_valid=0; o_tok_kind=0; o_tok_index=0; o_tok_value=0; o_tok_long=0. Reset mid-word or mid-lookup discards the partial word; no token is produced.
- Delimiters: 0x20, 0x09, 0x0A, 0x0D, 0x00. NUL is a delimiter because an all-zero key marks an empty dictionary slot.
- COLLECT: o_char_ready=1.
  - On an accepted non-delimiter: if length<KEY_LENGTH, write key[length]; else set the long flag and drop the character. Then increment the length (saturate at KEY_LENGTH+1). Update the number tracker.
  - On an accepted delimiter: if length==0, stay in COLLECT. Otherwise go to LOOKUP.
- Number tracker:
  - A leading '-' as the first character sets the negate flag.
  - Each '0'-'9' updates acc = acc*10 + digit, modulo 2^VALUE_WIDTH.
  - Any other character, or '-' in any position other than first, clears is_num.
  - A word consisting only of "-" is not a number.
  - Literal = negate ? -acc : acc, two's complement, VALUE_WIDTH bits.
- LOOKUP (1 cycle): o_dict_ready=1 and o_char_ready=0. Next state WAIT.
- WAIT: o_dict_ready=0. o_dict_key is held stable from LOOKUP until WAIT exits. i_dict_done is sampled only from the cycle after LOOKUP.
  - On done with err=0: token WORD, index and value taken from the dictionary.
  - On done with err=1: NUMBER if is_num, else UNDEFINED. Dictionary lookup has priority over number parsing.
  - Either way, go to EMIT.
- EMIT: o_tok_valid=1 and o_char_ready=0. Token fields are stable until i_tok_ready=1. On accept: o_tok_valid drops next cycle, key/length/acc/flags clear, and the state returns to COLLECT.
- Throughput: at most one word in flight. Minimum word-to-token latency from the delimiter is 4 cycles (delimiter, LOOKUP, two dictionary cycles).
- i_en=0 freezes every register, including a pending o_dict_ready. The dictionary is assumed to share the enable.

Optional Feature:
WORD_TOKENIZER_CASE_FOLD_EN
- Defined: 'a'-'z' are converted to 'A'-'Z' before the key write, so lookups are case-insensitive. Number tracking is unaffected.
- Undefined: characters are stored verbatim.

Decomposition:
- Package forth_pkg holds:
  - dictionary opcode constants (OP_SET=0, OP_GET=1, OP_ENCODE=2, OP_SET_FAST=3, OP_GET_FAST=4, OP_DELETE=5, OP_DELETE_FAST=6);
  - token kind enum (TOK_WORD, TOK_NUMBER, TOK_UNDEF);
  - delimiter and ASCII constants.
- One sub-module, num_accum: the decimal accumulator with negate and is_num flags. It has clear, step, and char inputs and exposes the literal and is_num.

Test Plan:
- Dictionary preloaded with "DUP" at index 3, value 0x100; stream "DUP " -> o_dict_key={'D','U','P',0,0,0,0,0}, single o_dict_ready pulse, token WORD, index 3, value 0x100, long=0.
- Stream "123 " with dictionary miss -> NUMBER, value 123. Stream "-5 " -> NUMBER, value 0xFFFFFFFB. Stream "- " -> UNDEFINED, value 0.
- Stream "FOO\n" with miss -> UNDEFINED, index 0, value 0. Stream "   \t\r\n" -> no dictionary request, no token.
- Stream "ABCDEFGHIJ " with KEY_LENGTH=8 -> key "ABCDEFGH", long=1, one request only.
- Hold i_tok_ready=0 for 5 cycles during EMIT -> token fields constant, o_char_ready=0, no byte consumed. Release -> next word proceeds.
- Assert i_rst in WAIT -> all outputs return to reset values, no token, next word "DUP " resolves normally. With CASE_FOLD_EN defined, "dup " -> WORD, index 3.
